// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory boot loader.
package imem_pkg;
  localparam int          DEPTH    = 64;
  localparam int          AW       = 6;
  localparam int          DW       = 32;
  localparam logic [31:0] NOP_INSN = 32'hd503201f;

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} ld_state_t;
endpackage

// File: rtl/imem_ram.sv
// DEPTH x DW instruction array: one synchronous write port and one
// combinational read port. The array has no reset; the loader clears it.
module imem_ram #(
  parameter int DEPTH = imem_pkg::DEPTH,
  parameter int AW    = imem_pkg::AW,
  parameter int DW    = imem_pkg::DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];

  // Synchronous write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Zero-latency read for the fetch port.
  always_comb rdata = mem_q[raddr];
endmodule

// File: rtl/imem_loader.sv
// Boot controller: clears the instruction memory to NOPs, accepts a program
// over a valid/ready stream, then releases the CPU. A reload request in RUN
// reopens loading without clearing the array again.
module imem_loader #(
  parameter int DEPTH = imem_pkg::DEPTH,
  parameter int AW    = imem_pkg::AW,
  parameter int DW    = imem_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_q,
  output logic          cpu_run,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic          ld_start,
  output logic          ld_overflow,
  output logic [AW:0]   loaded_words
);
  import imem_pkg::*;

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  ld_state_t     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   loaded_q, loaded_d;
  logic          ovf_q, ovf_d;

  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  imem_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (ptr_q),
    .wdata (wdata),
    .raddr (fetch_addr),
    .rdata (rdata)
  );

  // State, pointer, word count and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      loaded_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      loaded_q <= loaded_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and write control. ld_ready is a pure function of state so
  // it never depends on ld_valid.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
    wdata    = ld_data;
    cpu_run  = 1'b0;
    ld_ready = 1'b0;
    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        wdata = DW'(NOP_INSN);
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == PTR_LAST) state_d = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          we       = 1'b1;
          ptr_d    = ptr_q + AW'(1);
          loaded_d = loaded_q + (AW+1)'(1);
          if (ld_last) begin
            state_d = RUN;
          end else if (ptr_q == PTR_LAST) begin
            // Array full with no end marker: flag it and stop accepting.
            ovf_d   = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cpu_run = 1'b1;
        if (ld_start) begin
          state_d  = LOAD;
          ptr_d    = '0;
          loaded_d = '0;
          ovf_d    = 1'b0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // The CPU only sees memory contents while it is allowed to run.
  always_comb fetch_q = cpu_run ? rdata : DW'(NOP_INSN);

  assign ld_overflow  = ovf_q;
  assign loaded_words = loaded_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clear timing, load, backpressure,
// full-array completion, overflow, reload and asynchronous reset mid-load.
module tb_imem_loader;
  localparam logic [31:0] NOP = 32'hd503201f;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  fetch_addr = '0;
  logic [31:0] fetch_q;
  logic        cpu_run;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_start = 1'b0;
  logic        ld_overflow;
  logic [6:0]  loaded_words;

  int total = 0;
  int bad   = 0;

  imem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_addr   (fetch_addr),
    .fetch_q      (fetch_q),
    .cpu_run      (cpu_run),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_start     (ld_start),
    .ld_overflow  (ld_overflow),
    .loaded_words (loaded_words)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change and outputs are
  // sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if ({cpu_run, ld_ready, ld_overflow} !== 3'b000 || loaded_words !== 7'd0 || fetch_q !== NOP) begin
      bad++;
      $display("FAIL reset_values run=%b rdy=%b ovf=%b words=%0d q=%h want 0 0 0 0 %h",
               cpu_run, ld_ready, ld_overflow, loaded_words, fetch_q, NOP);
    end
    reset = 1'b1;
    ld_start = 1'b1;  // must be ignored during CLEAR
    for (int i = 1; i <= 64; i++) begin
      fetch_addr = 6'(i);
      tick();
      total++;
      if (ld_ready !== (i == 64) || cpu_run !== 1'b0 || fetch_q !== NOP) begin
        bad++;
        $display("FAIL clear_cycle%0d rdy=%b run=%b q=%h want rdy=%b run=0 q=%h",
                 i, ld_ready, cpu_run, fetch_q, (i == 64), NOP);
      end
    end
    ld_start = 1'b0;
  endtask

  task automatic test_load5();
    logic [31:0] prog [5];
    prog[0] = 32'h91003c0a; prog[1] = NOP; prog[2] = NOP; prog[3] = NOP; prog[4] = 32'hf800000a;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 4);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    total++;
    if (cpu_run !== 1'b1 || ld_ready !== 1'b0 || loaded_words !== 7'd5 || ld_overflow !== 1'b0) begin
      bad++;
      $display("FAIL load5_state run=%b rdy=%b words=%0d ovf=%b want 1 0 5 0",
               cpu_run, ld_ready, loaded_words, ld_overflow);
    end
    for (int a = 0; a < 64; a++) begin
      fetch_addr = 6'(a);
      #1;
      total++;
      if (fetch_q !== ((a < 5) ? prog[a] : NOP)) begin
        bad++;
        $display("FAIL load5_word%0d got=%h want=%h", a, fetch_q, (a < 5) ? prog[a] : NOP);
      end
    end
  endtask

  task automatic test_reload();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    total++;
    if (cpu_run !== 1'b0 || ld_ready !== 1'b1 || loaded_words !== 7'd0) begin
      bad++;
      $display("FAIL reload_enter run=%b rdy=%b words=%0d want 0 1 0", cpu_run, ld_ready, loaded_words);
    end
    ld_valid = 1'b1; ld_data = 32'hAAAA0001; ld_last = 1'b0;
    tick();
    ld_data = 32'hAAAA0002; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    total++;
    if (cpu_run !== 1'b1 || loaded_words !== 7'd2 || ld_overflow !== 1'b0) begin
      bad++;
      $display("FAIL reload_done run=%b words=%0d ovf=%b want 1 2 0", cpu_run, loaded_words, ld_overflow);
    end
    fetch_addr = 6'd0; #1;
    total++;
    if (fetch_q !== 32'hAAAA0001) begin bad++; $display("FAIL reload_w0 got=%h want=aaaa0001", fetch_q); end
    fetch_addr = 6'd1; #1;
    total++;
    if (fetch_q !== 32'hAAAA0002) begin bad++; $display("FAIL reload_w1 got=%h want=aaaa0002", fetch_q); end
    fetch_addr = 6'd4; #1;
    total++;
    if (fetch_q !== 32'hf800000a) begin bad++; $display("FAIL reload_w4 got=%h want=f800000a", fetch_q); end
  endtask

  task automatic test_backpressure();
    int acc;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    acc = 0;
    // valid low on even steps; garbage data there must never be written
    for (int s = 0; s < 6; s++) begin
      ld_valid = s[0];
      ld_data  = s[0] ? (32'hC0000000 + 32'(acc)) : 32'hDEADBEEF;
      ld_last  = s[0] && (acc == 2);
      tick();
      if (s[0]) acc++;
      total++;
      if (cpu_run !== (acc == 3) || loaded_words !== 7'(acc)) begin
        bad++;
        $display("FAIL bp_step%0d run=%b words=%0d want run=%b words=%0d",
                 s, cpu_run, loaded_words, (acc == 3), acc);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    for (int a = 0; a < 5; a++) begin
      logic [31:0] exp;
      exp = (a < 3) ? (32'hC0000000 + 32'(a)) : ((a == 3) ? NOP : 32'hf800000a);
      fetch_addr = 6'(a);
      #1;
      total++;
      if (fetch_q !== exp) begin bad++; $display("FAIL bp_word%0d got=%h want=%h", a, fetch_q, exp); end
    end
  endtask

  // Fill all 64 words; when with_last is set the 64th carries ld_last.
  task automatic fill64(input logic with_last, input logic [31:0] base);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1; ld_data = base + 32'(i); ld_last = with_last && (i == 63);
      tick();
    end
    ld_last = 1'b0;
  endtask

  task automatic test_full_last();
    fill64(1'b1, 32'h70000000);
    ld_valid = 1'b0;
    total++;
    if (cpu_run !== 1'b1 || ld_overflow !== 1'b0 || loaded_words !== 7'd64) begin
      bad++;
      $display("FAIL full_last run=%b ovf=%b words=%0d want 1 0 64", cpu_run, ld_overflow, loaded_words);
    end
  endtask

  task automatic test_overflow();
    fill64(1'b0, 32'h50000000);
    total++;
    if (cpu_run !== 1'b1 || ld_overflow !== 1'b1 || loaded_words !== 7'd64) begin
      bad++;
      $display("FAIL ovf_flag run=%b ovf=%b words=%0d want 1 1 64", cpu_run, ld_overflow, loaded_words);
    end
    ld_data = 32'h50000040;  // 65th word, still valid, must be dropped
    tick();
    ld_valid = 1'b0;
    fetch_addr = 6'd0; #1;
    total++;
    if (fetch_q !== 32'h50000000 || loaded_words !== 7'd64 || ld_overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_drop w0=%h words=%0d ovf=%b want 50000000 64 1", fetch_q, loaded_words, ld_overflow);
    end
    fetch_addr = 6'd63; #1;
    total++;
    if (fetch_q !== 32'h5000003f) begin bad++; $display("FAIL ovf_w63 got=%h want=5000003f", fetch_q); end
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    total++;
    if (ld_overflow !== 1'b0 || loaded_words !== 7'd0 || ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL ovf_clear ovf=%b words=%0d rdy=%b want 0 0 1", ld_overflow, loaded_words, ld_ready);
    end
  endtask

  // Enters already in LOAD (from test_overflow).
  task automatic test_reset_midload();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 32'hD0000000 + 32'(i);
      tick();
    end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({cpu_run, ld_ready, ld_overflow} !== 3'b000 || loaded_words !== 7'd0 || fetch_q !== NOP) begin
      bad++;
      $display("FAIL midload_reset run=%b rdy=%b ovf=%b words=%0d q=%h want 0 0 0 0 %h",
               cpu_run, ld_ready, ld_overflow, loaded_words, fetch_q, NOP);
    end
    ld_valid = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      total++;
      if (ld_ready !== (i == 64)) begin
        bad++;
        $display("FAIL reclear_cycle%0d rdy=%b want %b", i, ld_ready, (i == 64));
      end
    end
    ld_valid = 1'b1; ld_data = 32'hE0000000; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    for (int a = 0; a < 64; a++) begin
      fetch_addr = 6'(a);
      #1;
      total++;
      if (fetch_q !== ((a == 0) ? 32'hE0000000 : NOP)) begin
        bad++;
        $display("FAIL reclear_word%0d got=%h want=%h", a, fetch_q, (a == 0) ? 32'hE0000000 : NOP);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load5();
    test_reload();
    test_backpressure();
    test_full_last();
    test_overflow();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
